// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle MIPS-subset control FSM with bounded memory waits
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   OpCode, funct             instruction fields (sampled in DECODE)
//   Zero                      ALU zero flag (branch decision)
//   mem_ready                 memory access completes this cycle
//   pc_we, pc_src             PC write enable / PC source (00 PC+4, 01 branch, 10 jump)
//   IorD, MemR, MemW, IRWr    memory address select, read/write strobes, IR write
//   RegDst, Mem2R, RegW       register-file destination, write-back source, write
//   AluSrcA, AluSrcB, ExtOp   ALU operand selects, sign-extend enable
//   Aluctrl                   ALU operation code
//   instr_done, illegal       instruction retired / unsupported instruction seen
//   mem_err                   memory wait exceeded WAIT_LIMIT
//   state                     current FSM state code
module multi_cycle_ctrl #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OpCode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       IorD,
    output logic       MemR,
    output logic       MemW,
    output logic       IRWr,
    output logic       RegDst,
    output logic       Mem2R,
    output logic       RegW,
    output logic       AluSrcA,
    output logic       ExtOp,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_err,
    output logic [1:0] pc_src,
    output logic [1:0] AluSrcB,
    output logic [4:0] Aluctrl,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9
    } state_t;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_ADDU = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_SUBU = 5'd3;
    localparam logic [4:0] ALU_AND  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_XOR  = 5'd6;
    localparam logic [4:0] ALU_NOR  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_LUI  = 5'd10;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam logic [3:0] WLIM = 4'(WAIT_LIMIT);

    state_t     cur_state, nxt_state;
    logic [5:0] op_q, fn_q;
    logic [3:0] wcnt, wcnt_nxt;
    logic       timeout;

    // Supported R-type function codes and their ALU operations.
    function automatic logic rtype_ok(input logic [5:0] f);
        case (f)
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
            6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: rtype_ok = 1'b1;
            default:                           rtype_ok = 1'b0;
        endcase
    endfunction

    function automatic logic [4:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'h21:   rtype_alu = ALU_ADDU;
            6'h22:   rtype_alu = ALU_SUB;
            6'h23:   rtype_alu = ALU_SUBU;
            6'h24:   rtype_alu = ALU_AND;
            6'h25:   rtype_alu = ALU_OR;
            6'h26:   rtype_alu = ALU_XOR;
            6'h27:   rtype_alu = ALU_NOR;
            6'h2a:   rtype_alu = ALU_SLT;
            6'h2b:   rtype_alu = ALU_SLTU;
            default: rtype_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= FETCH;
            op_q      <= 6'd0;
            fn_q      <= 6'd0;
            wcnt      <= 4'd0;
        end else begin
            cur_state <= nxt_state;
            wcnt      <= wcnt_nxt;
            if (cur_state == DECODE) begin
                op_q <= OpCode;
                fn_q <= funct;
            end
        end
    end

    always_comb begin
        pc_we      = 1'b0;
        IorD       = 1'b0;
        MemR       = 1'b0;
        MemW       = 1'b0;
        IRWr       = 1'b0;
        RegDst     = 1'b0;
        Mem2R      = 1'b0;
        RegW       = 1'b0;
        AluSrcA    = 1'b0;
        ExtOp      = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        mem_err    = 1'b0;
        pc_src     = 2'b00;
        AluSrcB    = 2'b00;
        Aluctrl    = ALU_ADD;
        state      = cur_state;
        nxt_state  = cur_state;
        timeout    = (wcnt == WLIM) && !mem_ready;

        case (cur_state)
            FETCH: begin
                MemR    = 1'b1;
                AluSrcB = 2'b01;
                Aluctrl = ALU_ADDU;
                if (mem_ready) begin
                    IRWr      = 1'b1;
                    pc_we     = 1'b1;
                    nxt_state = DECODE;
                end else if (timeout) begin
                    mem_err = 1'b1;   // stay in FETCH, counter restarts
                end
            end
            DECODE: begin
                AluSrcB = 2'b11;
                ExtOp   = 1'b1;
                Aluctrl = ALU_ADD;
                // Decode from the live fields; the latched copy is only valid next cycle.
                case (OpCode)
                    OP_R: begin
                        if (rtype_ok(funct)) begin
                            nxt_state = EXEC;
                        end else begin
                            illegal   = 1'b1;
                            nxt_state = FETCH;
                        end
                    end
                    OP_ORI, OP_LUI: nxt_state = EXEC;
                    OP_LW, OP_SW:   nxt_state = MEMADR;
                    OP_BEQ:         nxt_state = BRANCH;
                    OP_J:           nxt_state = JUMP;
                    default: begin
                        illegal   = 1'b1;
                        nxt_state = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                AluSrcA   = 1'b1;
                AluSrcB   = 2'b10;
                ExtOp     = 1'b1;
                Aluctrl   = ALU_ADD;
                nxt_state = (op_q == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD = 1'b1;
                MemR = 1'b1;
                if (mem_ready) begin
                    nxt_state = MEMWB;
                end else if (timeout) begin
                    mem_err   = 1'b1;
                    nxt_state = FETCH;
                end
            end
            MEMWB: begin
                Mem2R      = 1'b1;
                RegW       = 1'b1;
                instr_done = 1'b1;
                nxt_state  = FETCH;
            end
            MEMWR: begin
                IorD = 1'b1;
                MemW = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt_state  = FETCH;
                end else if (timeout) begin
                    mem_err   = 1'b1;
                    nxt_state = FETCH;
                end
            end
            EXEC: begin
                AluSrcB = 2'b10;
                if (op_q == OP_LUI) begin
                    Aluctrl = ALU_LUI;
                end else if (op_q == OP_ORI) begin
                    AluSrcA = 1'b1;
                    Aluctrl = ALU_OR;
                end else begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b00;
                    Aluctrl = rtype_alu(fn_q);
                end
                nxt_state = ALUWB;
            end
            ALUWB: begin
                RegW       = 1'b1;
                RegDst     = (op_q == OP_R);
                instr_done = 1'b1;
                nxt_state  = FETCH;
            end
            BRANCH: begin
                AluSrcA    = 1'b1;
                Aluctrl    = ALU_SUB;
                pc_src     = 2'b01;
                pc_we      = Zero;
                instr_done = 1'b1;
                nxt_state  = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_we      = 1'b1;
                instr_done = 1'b1;
                nxt_state  = FETCH;
            end
            default: nxt_state = FETCH;
        endcase

        // Counter restarts whenever the state changes or a timeout fires.
        if (nxt_state != cur_state || mem_err) begin
            wcnt_nxt = 4'd0;
        end else if (!mem_ready && (cur_state == FETCH || cur_state == MEMRD || cur_state == MEMWR)) begin
            wcnt_nxt = wcnt + 4'd1;
        end else begin
            wcnt_nxt = wcnt;
        end

        // Reset silences every output in the same cycle it is asserted.
        if (rst) begin
            pc_we      = 1'b0;
            IorD       = 1'b0;
            MemR       = 1'b0;
            MemW       = 1'b0;
            IRWr       = 1'b0;
            RegDst     = 1'b0;
            Mem2R      = 1'b0;
            RegW       = 1'b0;
            AluSrcA    = 1'b0;
            ExtOp      = 1'b0;
            instr_done = 1'b0;
            illegal    = 1'b0;
            mem_err    = 1'b0;
            pc_src     = 2'b00;
            AluSrcB    = 2'b00;
            Aluctrl    = 5'd0;
            state      = 4'd0;
            nxt_state  = FETCH;
        end
    end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - randomized instruction-level bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;

    localparam int WAIT_LIMIT = 15;

    localparam logic [4:0] A_ADD = 5'd0, A_ADDU = 5'd1, A_SUB = 5'd2, A_SUBU = 5'd3,
                           A_AND = 5'd4, A_OR = 5'd5, A_XOR = 5'd6, A_NOR = 5'd7,
                           A_SLT = 5'd8, A_SLTU = 5'd9, A_LUI = 5'd10;

    localparam logic [5:0] OP_R = 6'h00, OP_ORI = 6'h0d, OP_LUI = 6'h0f, OP_LW = 6'h23,
                           OP_SW = 6'h2b, OP_BEQ = 6'h04, OP_J = 6'h02;

    typedef enum int {K_R, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

    typedef struct packed {
        logic       pc_we, iord, memr, memw, irwr, regdst, mem2r, regw,
                    alusrca, extop, done, illegal, mem_err;
        logic [1:0] pc_src, alusrcb;
        logic [4:0] aluctrl;
        logic [3:0] state;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] OpCode, funct;
    logic       Zero, mem_ready;
    logic       pc_we, IorD, MemR, MemW, IRWr, RegDst, Mem2R, RegW, AluSrcA, ExtOp;
    logic       instr_done, illegal, mem_err;
    logic [1:0] pc_src, AluSrcB;
    logic [4:0] Aluctrl;
    logic [3:0] state;

    ov_t got, e;
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  last_cycles;
    int  zero_force = -1;

    multi_cycle_ctrl #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .funct(funct), .Zero(Zero),
        .mem_ready(mem_ready), .pc_we(pc_we), .IorD(IorD), .MemR(MemR), .MemW(MemW),
        .IRWr(IRWr), .RegDst(RegDst), .Mem2R(Mem2R), .RegW(RegW), .AluSrcA(AluSrcA),
        .ExtOp(ExtOp), .instr_done(instr_done), .illegal(illegal), .mem_err(mem_err),
        .pc_src(pc_src), .AluSrcB(AluSrcB), .Aluctrl(Aluctrl), .state(state)
    );

    always #5 clk = ~clk;

    assign got = {pc_we, IorD, MemR, MemW, IRWr, RegDst, Mem2R, RegW, AluSrcA, ExtOp,
                  instr_done, illegal, mem_err, pc_src, AluSrcB, Aluctrl, state};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, expv, cyc);
        end
    endtask

    // Compare outputs mid-cycle, then advance one clock; garbage appears on the
    // instruction fields outside DECODE so any use of the live fields shows up.
    task automatic tick(input string tag);
        #3;
        check(tag, 32'(got), 32'(e));
        @(posedge clk);
        #1;
        cyc++;
        OpCode = 6'($urandom);
        funct  = 6'($urandom);
    endtask

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_R: begin
                case (fn)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b:
                        return K_R;
                    default: return K_ILL;
                endcase
            end
            OP_ORI:  return K_ORI;
            OP_LUI:  return K_LUI;
            OP_LW:   return K_LW;
            OP_SW:   return K_SW;
            OP_BEQ:  return K_BEQ;
            OP_J:    return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [4:0] ref_alu(input logic [5:0] fn);
        case (fn)
            6'h20: return A_ADD;   6'h21: return A_ADDU;
            6'h22: return A_SUB;   6'h23: return A_SUBU;
            6'h24: return A_AND;   6'h25: return A_OR;
            6'h26: return A_XOR;   6'h27: return A_NOR;
            6'h2a: return A_SLT;   default: return A_SLTU;
        endcase
    endfunction

    // One memory-waiting state: k stall cycles precede mem_ready. Returns ok=0 on
    // timeout or when reset is applied after rst_after stalls.
    task automatic mem_wait(input logic [3:0] st, input int k, input int rst_after, output bit ok);
        int n = 0;
        while (1) begin
            mem_ready = (n >= k);
            Zero      = 1'($urandom);
            if (n == rst_after) begin
                rst = 1'b1;
                mem_ready = 1'b1;
                e = '0;
                tick("rst_mid_instr");
                rst = 1'b0;
                ok = 0;
                return;
            end
            e = '0;
            e.state = st;
            if (st == 4'd0) begin
                e.memr = 1; e.alusrcb = 2'b01; e.aluctrl = A_ADDU;
            end else if (st == 4'd3) begin
                e.iord = 1; e.memr = 1;
            end else begin
                e.iord = 1; e.memw = 1;
            end
            if (mem_ready) begin
                if (st == 4'd0) begin e.irwr = 1; e.pc_we = 1; end
                if (st == 4'd5) e.done = 1;
                tick(st == 4'd0 ? "fetch_ready" : "mem_ready");
                ok = 1;
                return;
            end else if (n == WAIT_LIMIT) begin
                e.mem_err = 1;
                tick("mem_timeout");
                ok = 0;
                return;
            end
            tick("mem_stall");
            n++;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int kf, input int km, input int rst_mem);
        int    start = cyc;
        int    kf0 = kf;
        bit    ok = 0;
        bit    full = 0;
        kind_t k = classify(op, fn);
        int    lat;

        while (!ok) begin
            mem_wait(4'd0, kf, -1, ok);
            kf -= WAIT_LIMIT + 1;
        end

        OpCode = op; funct = fn; mem_ready = 1'($urandom); Zero = 1'($urandom);
        e = '0; e.state = 4'd1; e.alusrcb = 2'b11; e.extop = 1; e.aluctrl = A_ADD;
        e.illegal = (k == K_ILL);
        tick("decode");

        mem_ready = 1'($urandom); Zero = 1'($urandom);
        case (k)
            K_R, K_ORI, K_LUI: begin
                e = '0; e.state = 4'd6;
                if (k == K_R) begin
                    e.alusrca = 1; e.alusrcb = 2'b00; e.aluctrl = ref_alu(fn);
                end else if (k == K_ORI) begin
                    e.alusrca = 1; e.alusrcb = 2'b10; e.aluctrl = A_OR;
                end else begin
                    e.alusrcb = 2'b10; e.aluctrl = A_LUI;
                end
                tick("exec");
                e = '0; e.state = 4'd7; e.regw = 1; e.regdst = (k == K_R); e.done = 1;
                tick("aluwb");
                full = 1;
            end
            K_LW, K_SW: begin
                e = '0; e.state = 4'd2; e.alusrca = 1; e.alusrcb = 2'b10; e.extop = 1;
                e.aluctrl = A_ADD;
                tick("memadr");
                mem_wait(k == K_LW ? 4'd3 : 4'd5, km, rst_mem, ok);
                if (ok && k == K_LW) begin
                    mem_ready = 1'($urandom);
                    e = '0; e.state = 4'd4; e.mem2r = 1; e.regw = 1; e.done = 1;
                    tick("memwb");
                end
                full = ok;
            end
            K_BEQ: begin
                Zero = (zero_force < 0) ? 1'($urandom) : 1'(zero_force);
                e = '0; e.state = 4'd8; e.alusrca = 1; e.aluctrl = A_SUB;
                e.pc_src = 2'b01; e.pc_we = Zero; e.done = 1;
                tick("branch");
                full = 1;
            end
            K_J: begin
                e = '0; e.state = 4'd9; e.pc_src = 2'b10; e.pc_we = 1; e.done = 1;
                tick("jump");
                full = 1;
            end
            default: full = 1;
        endcase

        last_cycles = cyc - start;
        if (full && kf0 == 0 && km == 0) begin
            case (k)
                K_R, K_ORI, K_LUI, K_SW: lat = 4;
                K_LW:                    lat = 5;
                K_BEQ, K_J:              lat = 3;
                default:                 lat = 2;
            endcase
            check("latency", 32'(last_cycles), 32'(lat));
        end
    endtask

    function automatic int pick_stall();
        int r = $urandom_range(0, 19);
        if (r < 13) return 0;
        if (r < 19) return $urandom_range(1, 4);
        return $urandom_range(16, 20);
    endfunction

    initial begin
        logic [5:0] ops [7] = '{OP_R, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J};
        logic [5:0] fns [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                 6'h27, 6'h2a, 6'h2b};
        logic [5:0] op, fn;

        rst = 1'b1; OpCode = 6'h23; funct = 6'h21; Zero = 1'b1; mem_ready = 1'b1;
        e = '0;
        tick("reset_outputs");
        tick("reset_outputs");
        rst = 1'b0;

        run_instr(OP_R, 6'h21, 0, 0, -1);
        run_instr(OP_LW, 6'h00, 0, 3, -1);
        check("lw_wait_cycles", 32'(last_cycles), 32'd8);
        zero_force = 1;
        run_instr(OP_BEQ, 6'h00, 0, 0, -1);
        zero_force = 0;
        run_instr(OP_BEQ, 6'h00, 0, 0, -1);
        zero_force = -1;
        run_instr(6'h3f, 6'h00, 0, 0, -1);
        run_instr(OP_R, 6'h3f, 0, 0, -1);
        run_instr(OP_SW, 6'h00, 0, 40, -1);
        check("sw_timeout_cycles", 32'(last_cycles), 32'd19);
        run_instr(OP_R, 6'h2a, 20, 0, -1);
        run_instr(OP_LW, 6'h00, 0, 10, 2);
        run_instr(OP_ORI, 6'h00, 0, 0, -1);
        run_instr(OP_LUI, 6'h00, 0, 0, -1);
        run_instr(OP_J, 6'h00, 0, 0, -1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 6)];
                fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 9)];
            end
            run_instr(op, fn, pick_stall(), pick_stall(), -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
